// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, 8N1 serial output at CLKS_PER_BIT clocks per bit.
// Define UART_TX_PARITY_EN to add an even parity bit after data bit 7 (8E1).
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_txd,
  output logic       tx_busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (tx_valid && ready_q) begin
          shift_d  = tx_data;
          cnt_d    = '0;
          idx_d    = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the line changes on the transition edge.
  always_comb begin
    txd_d   = 1'b1;
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    unique case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = parity_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  assign tx_ready = ready_q;
  assign uart_txd = txd_q;
  assign tx_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=4: table vectors, corner sequences,
// and a randomized stream checked by a serial receiver model.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int unsigned N = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, uart_txd, tx_busy;

  int checks = 0;
  int failures = 0;

  uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_txd(uart_txd), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // frame bit p = line level during serial bit slot p (slot 0 = start bit)
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t vecs[8];

  function automatic logic exp_bit(input vec_t v, input int unsigned p);
    if (p < 9) return v.frame[p];
`ifdef UART_TX_PARITY_EN
    if (p == 9) return v.par;
`endif
    return 1'b1;
  endfunction

  // Serial receiver model: samples each bit at its centre on the falling edge.
  logic       mon_en = 1'b0;
  logic [7:0] sent_q[$];
  int         rx_count = 0;

  always begin : rx_model
    logic [7:0] b;
    @(negedge clk);
    if (mon_en && uart_txd === 1'b0) begin
      b = '0;
      repeat (N / 2) @(negedge clk);
      check("rx_start", {31'd0, uart_txd}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (N) @(negedge clk);
        b[i] = uart_txd;
      end
`ifdef UART_TX_PARITY_EN
      repeat (N) @(negedge clk);
      check("rx_parity", {31'd0, uart_txd}, $countones(b) % 2);
`endif
      repeat (N) @(negedge clk);
      check("rx_stop", {31'd0, uart_txd}, 32'd1);
      if (sent_q.size() == 0) check("rx_unexpected_byte", {24'd0, b}, 32'hFFFF_FFFF);
      else check("rx_byte", {24'd0, b}, {24'd0, sent_q.pop_front()});
      rx_count++;
    end
  end

  initial begin
    vec_t v00, vff;
    logic [7:0] src[$];
    int cyc;

    vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    vecs[1] = '{8'h07, 10'b1_00000111_0, 1'b1};
    vecs[2] = '{8'h03, 10'b1_00000011_0, 1'b0};
    vecs[3] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vecs[4] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vecs[5] = '{8'h80, 10'b1_10000000_0, 1'b1};
    vecs[6] = '{8'h3C, 10'b1_00111100_0, 1'b0};
    vecs[7] = '{8'h5A, 10'b1_01011010_0, 1'b0};
    v00 = vecs[3];
    vff = vecs[4];

    // Reset held with valid asserted
    rst = 1'b0; tx_valid = 1'b1; tx_data = 8'h55;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("reset_txd",   {31'd0, uart_txd}, 32'd1);
      check("reset_ready", {31'd0, tx_ready}, 32'd0);
      check("reset_busy",  {31'd0, tx_busy},  32'd0);
    end
    rst = 1'b1; tx_valid = 1'b0;
    tick();
    check("release_ready", {31'd0, tx_ready}, 32'd1);
    check("release_busy",  {31'd0, tx_busy},  32'd0);
    check("release_txd",   {31'd0, uart_txd}, 32'd1);

    // Table vectors: full frame shape and ready return time
    for (int unsigned t = 0; t < 8; t++) begin
      tx_data = vecs[t].data; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0; tx_data = ~vecs[t].data;
      check("hs_busy",  {31'd0, tx_busy},  32'd1);
      check("hs_ready", {31'd0, tx_ready}, 32'd0);
      for (int unsigned p = 0; p < NB * N; p++) begin
        check("frame_bit",   {31'd0, uart_txd}, {31'd0, exp_bit(vecs[t], p / N)});
        check("frame_ready", {31'd0, tx_ready}, 32'd0);
        tick();
      end
      check("end_ready", {31'd0, tx_ready}, 32'd1);
      check("end_busy",  {31'd0, tx_busy},  32'd0);
      check("end_txd",   {31'd0, uart_txd}, 32'd1);
    end

    // Back-to-back with valid held high; data changes mid-frame
    tx_data = 8'h00; tx_valid = 1'b1;
    tick();
    tx_data = 8'hFF;
    for (int unsigned p = 0; p < NB * N; p++) begin
      check("b2b_frame0", {31'd0, uart_txd}, {31'd0, exp_bit(v00, p / N)});
      tick();
    end
    check("b2b_gap_txd",   {31'd0, uart_txd}, 32'd1);
    check("b2b_gap_ready", {31'd0, tx_ready}, 32'd1);
    tick();
    tx_valid = 1'b0; tx_data = 8'h12;
    for (int unsigned p = 0; p < NB * N; p++) begin
      check("b2b_frame1", {31'd0, uart_txd}, {31'd0, exp_bit(vff, p / N)});
      tick();
    end
    check("b2b_end_ready", {31'd0, tx_ready}, 32'd1);

    // Reset during data bit 3 of 0x3C
    tx_data = 8'h3C; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (4 * N + 1) tick();
    check("mid_busy", {31'd0, tx_busy}, 32'd1);
    rst = 1'b0;
    tick();
    check("midrst_txd",   {31'd0, uart_txd}, 32'd1);
    check("midrst_busy",  {31'd0, tx_busy},  32'd0);
    check("midrst_ready", {31'd0, tx_ready}, 32'd0);
    rst = 1'b1;
    tick();
    check("midrst_release_ready", {31'd0, tx_ready}, 32'd1);
    for (int unsigned i = 0; i < 12 * N; i++) begin
      tick();
      check("no_resend_txd", {31'd0, uart_txd}, 32'd1);
    end
    check("no_resend_busy", {31'd0, tx_busy}, 32'd0);

    // Randomized stream from an upstream buffer model
    for (int i = 0; i < 256; i++) src.push_back(8'($urandom));
    mon_en = 1'b1;
    cyc = 0;
    while (src.size() > 0 && cyc < 40000) begin
      bit hs;
      if (!tx_valid) begin
        if ($urandom_range(0, 3) == 0) tx_data = 8'($urandom);
        else begin
          tx_valid = 1'b1;
          tx_data  = src[0];
        end
      end
      hs = tx_valid && tx_ready;
      tick();
      cyc++;
      if (hs) begin
        sent_q.push_back(src.pop_front());
        tx_valid = 1'b0;
      end
    end
    tx_valid = 1'b0;
    cyc = 0;
    while (rx_count < 256 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("rand_src_drained", src.size(), 32'd0);
    check("rand_rx_count", rx_count, 32'd256);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
